rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Register-file write-back arbiter for the RISC-V core. It shares the single regfile write port (`rf_write_en` / `rf_write_reg` / `rf_write_data`) between two requesters: the ALU result path and the load-data return path. A write granted in cycle N is driven registered on the write port in cycle N+1. The block also exposes in-flight write data to the decoder's rs1/rs2 read ports for forwarding.

## Interface
Parameters:
- `XLEN`, 32, data width
- `REG_ADDR_W`, 5, register address width
- `MAX_WAIT`, 4, consecutive ALU denials before the ALU is forced a grant (1..15)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `alu_valid`  in  1  ALU write-back request
- `alu_rd`  in  REG_ADDR_W  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle
- `ld_valid`  in  1  load write-back request
- `ld_rd`  in  REG_ADDR_W  load destination register
- `ld_data`  in  XLEN  load data
- `ld_ready`  out  1  load request accepted this cycle
- `rf_write_en`  out  1  regfile write enable
- `rf_write_reg`  out  REG_ADDR_W  regfile write address
- `rf_write_data`  out  XLEN  regfile write data
- `rs1_addr`, `rs2_addr`  in  REG_ADDR_W  decoder source addresses
- `fwd_rs1_hit`, `fwd_rs2_hit`  out  1  source matches the in-flight write
- `fwd_rs1_data`, `fwd_rs2_data`  out  XLEN  in-flight write data

## Operation
- A transfer occurs when `valid && ready`. The `ready` outputs are combinational from the valid inputs and the age state, and never depend on `ready`.
- Grant rules:
  - One requester valid: that requester is granted.
  - Both valid: the load wins by default.
  - Both valid and the ALU is starved (see Configuration): the ALU wins.
- Each cycle at most one `ready` is high.
- The granted rd and data are registered into the write stage. `rf_write_en` is 1 only if the granted rd != 0.
- A write to x0 is accepted (`ready` = 1) but produces no write: `rf_write_en` = 0 and the reg/data outputs hold their previous values.
- With no grant, `rf_write_en` = 0 next cycle and the reg/data outputs hold.
- Forwarding:
  - `fwd_rsN_hit = rf_write_en && (rsN_addr == rf_write_reg) && rsN_addr != 0`
  - `fwd_rsN_data = rf_write_data`
  - The forwarding outputs are purely combinational from the registered stage.
- Requesters must hold rd and data stable while valid and not ready. The arbiter does not check this.

## Timing
- Latency: accept at edge N, write visible on the port during cycle N+1. Throughput is 1 write per cycle.
- Reset values:
  - `rf_write_en` = 0, `rf_write_reg` = 0, `rf_write_data` = 0, age counter = 0.
  - `fwd_*_hit` = 0.
  - `ready` outputs follow their combinational rules (0 when no valid).
- Reset asserted mid-operation: the in-flight write is discarded immediately (asynchronous) and the age counter clears. Requests held through reset are granted normally after deassertion.
- Simultaneous same rd from both requesters: only the granted one writes. The loser writes on a later cycle, so the last write wins in grant order.

## Configuration
- `RF_WB_AGE_EN` defined:
  - A counter (width ceil(log2(MAX_WAIT+1))) increments each cycle `alu_valid && !alu_ready`, and clears on ALU accept or when `alu_valid` = 0.
  - When the counter equals `MAX_WAIT` and both requesters are valid, the ALU is granted and the load is stalled for one cycle.
- `RF_WB_AGE_EN` undefined: strict load priority, no counter logic, and the ALU may starve indefinitely.

## Structure
- Shared package `rv_core_pkg`: `XLEN`, `REG_ADDR_W`, `REG_X0` constant, and a `wb_src_e` enum {`WB_NONE`, `WB_ALU`, `WB_LD`}.
- One natural sub-module: `rf_fwd_cmp` (address compare plus hit/data for one source port), instantiated twice.

## Test plan
- Reset release, `alu_valid` = 1, `alu_rd` = 1, `alu_data` = 15 -> `alu_ready` = 1; the next cycle `rf_write_en` = 1, `rf_write_reg` = 1, `rf_write_data` = 15.
- Both valid, `ld_rd` = 2 with data 10, `alu_rd` = 3 with data 7 -> `ld_ready` = 1 and `alu_ready` = 0; the next cycle writes reg 2 = 10, and the cycle after writes reg 3 = 7.
- `RF_WB_AGE_EN`, `MAX_WAIT` = 4, `ld_valid` held 1, `alu_valid` held 1 -> `alu_ready` rises in the 5th cycle. Without the macro, `alu_ready` stays 0 for 20 cycles.
- `alu_rd` = 0 with data 99 -> `alu_ready` = 1, then `rf_write_en` = 0 and `fwd_rs1_hit` = 0 for `rs1_addr` = 0.
- Write reg 1 = 15 in flight with `rs1_addr` = 1 and `rs2_addr` = 2 -> `fwd_rs1_hit` = 1, `fwd_rs1_data` = 15, `fwd_rs2_hit` = 0.
- Assert `rst` while `rf_write_en` = 1 -> `rf_write_en` = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath widths, the x0 register index and the
// write-back source selector used by the regfile write-back arbiter.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rf_fwd_cmp.sv
// Forwarding comparator for one decoder source port: flags a hit when the
// source register matches the write currently on the regfile port. x0 never
// hits because it is hard-wired to zero in the regfile.
module rf_fwd_cmp #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  wr_en_i,
  input  logic [REG_ADDR_W-1:0] wr_reg_i,
  input  logic [XLEN-1:0]       wr_data_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  output logic                  hit_o,
  output logic [XLEN-1:0]       data_o
);

  // Hit when the in-flight write targets this non-zero source register.
  always_comb begin
    hit_o  = wr_en_i && (rs_addr_i == wr_reg_i) && (rs_addr_i != '0);
    data_o = wr_data_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-back arbiter: shares the single regfile write port between
// the ALU result path and the load return path. Loads win ties. A grant in
// cycle N appears registered on the write port in cycle N+1, and that stage
// is also offered to the decoder for rs1/rs2 forwarding.
// Optional feature macro: RF_WB_AGE_EN -- ALU anti-starvation age counter;
// after MAX_WAIT consecutive denials the ALU beats a pending load.
module rf_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int XLEN       = rv_core_pkg::XLEN,
  parameter int REG_ADDR_W = rv_core_pkg::REG_ADDR_W,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  ld_ready,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]       rf_write_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [XLEN-1:0]       fwd_rs1_data,
  output logic [XLEN-1:0]       fwd_rs2_data
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("rf_wb_arbiter: MAX_WAIT must be within 1..15");
  end

  localparam logic [REG_ADDR_W-1:0] RD_X0 = REG_ADDR_W'(REG_X0);

  wb_src_e               grant;
  logic                  alu_starved;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic [XLEN-1:0]       grant_data;

  logic                  wr_en_q,   wr_en_d;
  logic [REG_ADDR_W-1:0] wr_reg_q,  wr_reg_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;

`ifdef RF_WB_AGE_EN
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age_q, age_d;

  // Count consecutive ALU denials; any cycle without a pending-and-denied
  // ALU request restarts the count. Saturates at the starvation threshold.
  always_comb begin
    age_d = '0;
    if (alu_valid && !alu_ready) begin
      age_d = (age_q == AGE_MAX) ? age_q : age_q + 1'b1;
    end
  end

  // Age counter register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign alu_starved = (age_q == AGE_MAX);
`else
  // Strict load priority: the ALU is never considered starved.
  assign alu_starved = 1'b0;
`endif

  // Pick the winner: load by default, ALU when alone or starved.
  always_comb begin
    grant = WB_NONE;
    if (ld_valid && !(alu_valid && alu_starved)) begin
      grant = WB_LD;
    end else if (alu_valid) begin
      grant = WB_ALU;
    end
  end

  assign alu_ready = (grant == WB_ALU);
  assign ld_ready  = (grant == WB_LD);

  // Steer the granted destination/data and form the next write-stage
  // contents; x0 writes and idle cycles leave reg/data untouched.
  always_comb begin
    grant_rd   = RD_X0;
    grant_data = '0;
    case (grant)
      WB_ALU: begin
        grant_rd   = alu_rd;
        grant_data = alu_data;
      end
      WB_LD: begin
        grant_rd   = ld_rd;
        grant_data = ld_data;
      end
      default: begin
        grant_rd   = RD_X0;
        grant_data = '0;
      end
    endcase

    wr_en_d   = (grant != WB_NONE) && (grant_rd != RD_X0);
    wr_reg_d  = wr_en_d ? grant_rd   : wr_reg_q;
    wr_data_d = wr_en_d ? grant_data : wr_data_q;
  end

  // Write stage register; reset discards any in-flight write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_reg  = wr_reg_q;
  assign rf_write_data = wr_data_q;

  rf_fwd_cmp #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .wr_en_i   (wr_en_q),
    .wr_reg_i  (wr_reg_q),
    .wr_data_i (wr_data_q),
    .rs_addr_i (rs1_addr),
    .hit_o     (fwd_rs1_hit),
    .data_o    (fwd_rs1_data)
  );

  rf_fwd_cmp #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .wr_en_i   (wr_en_q),
    .wr_reg_i  (wr_reg_q),
    .wr_data_i (wr_data_q),
    .rs_addr_i (rs2_addr),
    .hit_o     (fwd_rs2_hit),
    .data_o    (fwd_rs2_data)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a grant/write-port model checked
// every falling edge, plus directed vectors with literal expectations.
module tb_rf_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, ld_valid;
  logic [AW-1:0]   alu_rd, ld_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0] alu_data, ld_data;
  logic            alu_ready, ld_ready, rf_write_en;
  logic [AW-1:0]   rf_write_reg;
  logic [XLEN-1:0] rf_write_data, fwd_rs1_data, fwd_rs2_data;
  logic            fwd_rs1_hit, fwd_rs2_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .XLEN       (XLEN),
    .REG_ADDR_W (AW),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_valid      (ld_valid),
    .ld_rd         (ld_rd),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs2_hit   (fwd_rs2_hit),
    .fwd_rs1_data  (fwd_rs1_data),
    .fwd_rs2_data  (fwd_rs2_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected write port contents and the number of consecutive cycles the
  // ALU has been kept waiting.
  logic            m_en   = 1'b0;
  logic [AW-1:0]   m_reg  = '0;
  logic [XLEN-1:0] m_data = '0;
  int              m_wait = 0;

  // 0 = nobody, 1 = ALU, 2 = load
  function automatic int m_winner();
    bit starved;
    starved = 1'b0;
`ifdef RF_WB_AGE_EN
    starved = (m_wait >= MAX_WAIT);
`endif
    if (ld_valid && !(alu_valid && starved)) return 2;
    if (alu_valid) return 1;
    return 0;
  endfunction

  int w_upd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en   <= 1'b0;
      m_reg  <= '0;
      m_data <= '0;
      m_wait <= 0;
    end else begin
      w_upd  = m_winner();
      m_wait <= (alu_valid && w_upd != 1) ? m_wait + 1 : 0;
      m_en   <= 1'b0;
      if (w_upd == 2 && ld_rd != 0) begin
        m_en <= 1'b1; m_reg <= ld_rd; m_data <= ld_data;
      end else if (w_upd == 1 && alu_rd != 0) begin
        m_en <= 1'b1; m_reg <= alu_rd; m_data <= alu_data;
      end
    end
  end

  int w_cmp;
  always @(negedge clk) begin
    w_cmp = m_winner();
    check("mdl_alu_ready", {31'b0, alu_ready}, {31'b0, w_cmp == 1});
    check("mdl_ld_ready", {31'b0, ld_ready}, {31'b0, w_cmp == 2});
    check("mdl_wr_en", {31'b0, rf_write_en}, {31'b0, m_en});
    check("mdl_wr_reg", {27'b0, rf_write_reg}, {27'b0, m_reg});
    check("mdl_wr_data", rf_write_data, m_data);
    check("mdl_rs1_hit", {31'b0, fwd_rs1_hit},
          {31'b0, m_en && rs1_addr == m_reg && rs1_addr != 0});
    check("mdl_rs2_hit", {31'b0, fwd_rs2_hit},
          {31'b0, m_en && rs2_addr == m_reg && rs2_addr != 0});
    check("mdl_rs1_data", fwd_rs1_data, m_data);
    check("mdl_rs2_data", fwd_rs2_data, m_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
    rs1_addr  = '0; rs2_addr = '0;
    #12;
    check("rst_wr_en", {31'b0, rf_write_en}, 0);
    check("rst_wr_reg", {27'b0, rf_write_reg}, 0);
    check("rst_wr_data", rf_write_data, 0);
    check("rst_rs1_hit", {31'b0, fwd_rs1_hit}, 0);
    check("rst_alu_ready", {31'b0, alu_ready}, 0);
    check("rst_ld_ready", {31'b0, ld_ready}, 0);
    tick();
    rst = 1'b0;

    // single ALU write x1 = 15, then forwarding
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'd15;
    #1;
    check("alu_only_ready", {31'b0, alu_ready}, 1);
    check("alu_only_ld_ready", {31'b0, ld_ready}, 0);
    tick();
    alu_valid = 0; rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    check("alu_wr_en", {31'b0, rf_write_en}, 1);
    check("alu_wr_reg", {27'b0, rf_write_reg}, 1);
    check("alu_wr_data", rf_write_data, 15);
    check("fwd_rs1_hit", {31'b0, fwd_rs1_hit}, 1);
    check("fwd_rs1_data", fwd_rs1_data, 15);
    check("fwd_rs2_hit", {31'b0, fwd_rs2_hit}, 0);

    // both valid: load first, ALU next
    tick();
    ld_valid  = 1; ld_rd  = 5'd2; ld_data  = 32'd10;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'd7;
    #1;
    check("both_ld_ready", {31'b0, ld_ready}, 1);
    check("both_alu_ready", {31'b0, alu_ready}, 0);
    tick();
    ld_valid = 0;
    #1;
    check("both_wr1_reg", {27'b0, rf_write_reg}, 2);
    check("both_wr1_data", rf_write_data, 10);
    check("both_alu_ready2", {31'b0, alu_ready}, 1);
    tick();
    alu_valid = 0;
    #1;
    check("both_wr2_en", {31'b0, rf_write_en}, 1);
    check("both_wr2_reg", {27'b0, rf_write_reg}, 3);
    check("both_wr2_data", rf_write_data, 7);

    // write to x0: accepted, no write, outputs hold
    tick();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'd99;
    #1;
    check("x0_ready", {31'b0, alu_ready}, 1);
    tick();
    alu_valid = 0; rs1_addr = 5'd0;
    #1;
    check("x0_wr_en", {31'b0, rf_write_en}, 0);
    check("x0_rs1_hit", {31'b0, fwd_rs1_hit}, 0);
    check("x0_hold_reg", {27'b0, rf_write_reg}, 3);
    check("x0_hold_data", rf_write_data, 7);

    // contention held for 20 cycles
    tick();
    ld_valid  = 1; ld_rd  = 5'd5; ld_data  = 32'd100;
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'd44;
    for (int i = 1; i <= 20; i++) begin
      #1;
`ifdef RF_WB_AGE_EN
      check("starve_alu_ready", {31'b0, alu_ready}, {31'b0, (i % 5) == 0});
`else
      check("starve_alu_ready", {31'b0, alu_ready}, 0);
`endif
      check("starve_ld_ready", {31'b0, ld_ready}, {31'b0, !alu_ready});
      tick();
    end
    ld_valid = 0; alu_valid = 0;
    tick();

    // same rd from both: load then ALU, last write wins
    ld_valid  = 1; ld_rd  = 5'd6; ld_data  = 32'd1;
    alu_valid = 1; alu_rd = 5'd6; alu_data = 32'd2;
    tick();
    ld_valid = 0;
    #1;
    check("same_rd_first", rf_write_data, 1);
    tick();
    alu_valid = 0;
    #1;
    check("same_rd_last_reg", {27'b0, rf_write_reg}, 6);
    check("same_rd_last_data", rf_write_data, 2);

    // asynchronous reset with a write in flight, request held through reset
    tick();
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'd77;
    tick();
    alu_rd = 5'd8; alu_data = 32'd88; rs1_addr = 5'd7;
    #1;
    check("pre_rst_wr_en", {31'b0, rf_write_en}, 1);
    check("pre_rst_rs1_hit", {31'b0, fwd_rs1_hit}, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_wr_en", {31'b0, rf_write_en}, 0);
    check("async_rst_wr_reg", {27'b0, rf_write_reg}, 0);
    check("async_rst_wr_data", rf_write_data, 0);
    check("async_rst_rs1_hit", {31'b0, fwd_rs1_hit}, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", {31'b0, alu_ready}, 1);
    tick();
    alu_valid = 0;
    #1;
    check("post_rst_wr_en", {31'b0, rf_write_en}, 1);
    check("post_rst_wr_reg", {27'b0, rf_write_reg}, 8);
    check("post_rst_wr_data", rf_write_data, 88);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
